// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch resolve / BTB update path.
//   IDX_W      : BTB index width, index = pc[IDX_W+1:2]
//   btb_upd_t  : one BTB write-back request {idx, target}
//   trk_t      : pipeline tracking record {v, pc, pred}
//   pc_to_idx  : maps a word-aligned PC onto its BTB index
package bpred_pkg;

    localparam int IDX_W = 7;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      target;
    } btb_upd_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] pred;
    } trk_t;

    // PC bits [1:0] are always zero for MIPS32, so the index starts at bit 2
    function automatic logic [IDX_W-1:0] pc_to_idx(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Synchronous valid/ready FIFO holding BTB update requests.
// A push into a full FIFO is discarded and flagged on o_drop, unless the
// head is popped in the same cycle, in which case both happen.
//   clk, rst     : clock, synchronous active-high reset
//   i_push       : enqueue request
//   i_push_data  : entry to enqueue
//   o_drop       : push lost because the FIFO was full with no pop
//   o_valid      : FIFO non-empty (head valid)
//   o_data       : head entry, reads 0 while empty
//   i_ready      : consumer takes the head this cycle
module bpred_upd_fifo
    import bpred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  btb_upd_t i_push_data,
    output logic     o_drop,
    output logic     o_valid,
    output btb_upd_t o_data,
    input  logic     i_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    btb_upd_t       r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Full/empty decode and push/pop qualification
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                  (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
        w_pop   = ~w_empty & i_ready;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts
        w_push  = i_push & (~w_full | w_pop);
        o_drop  = i_push & w_full & ~w_pop;
        o_valid = ~w_empty;
        if (w_empty) begin
            o_data = '0;
        end else begin
            o_data = r_mem[r_rd_ptr[PTR_W-1:0]];
        end
    end

    // Read/write pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are don't-care until the write pointer passes them
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: update-side partner of the fetch-stage BTB.
// Follows each fetched instruction's predicted next PC through ID and EX,
// compares it with the real next PC in EX, raises mispred/redirect/flush and
// queues BTB corrections for the BTB to drain via valid/ready.
// BTB index width comes from bpred_pkg::IDX_W.
//   clk, rst                         : clock, synchronous active-high reset
//   if_valid, if_pc, if_pred_npc     : IF instruction and its BTB prediction
//   stall                            : hazard stall, freezes ID/EX tracking
//   ex_is_branch, ex_taken, ex_target: EX branch resolution
//   mispred, redirect_pc, flush      : misprediction outcome (combinational)
//   upd_valid, upd_idx, upd_target   : head of BTB update queue
//   upd_ready                        : BTB accepts head
//   branch_cnt, mispred_cnt, drop_cnt: wrapping statistics counters
module branch_resolve_unit
    import bpred_pkg::*;
#(
    parameter int UPD_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_pred_npc,
    input  logic             stall,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             mispred,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_idx,
    output logic [31:0]      upd_target,
    input  logic             upd_ready,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    trk_t             r_id;
    trk_t             r_ex;
    logic             r_ex_done;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic        w_eval;
    logic [31:0] w_actual;
    logic        w_mispred;
    logic        w_drop;
    btb_upd_t    w_push_data;
    btb_upd_t    w_head;

    // EX evaluation: real next PC versus the prediction carried from IF
    always_comb begin
        // done blocks re-evaluation while a stalled instruction sits in EX
        w_eval = r_ex.v & ~r_ex_done;
        if (ex_is_branch && ex_taken) begin
            w_actual = ex_target;
        end else begin
            w_actual = r_ex.pc + 32'd4;
        end
        w_mispred          = w_eval & (w_actual != r_ex.pred);
        // Non-branch mispredicts come from aliased BTB entries; pushing pc+4
        // rewrites that entry to fall-through
        w_push_data.idx    = pc_to_idx(r_ex.pc);
        w_push_data.target = w_actual;
    end

    assign mispred     = w_mispred;
    assign flush       = w_mispred;
    assign redirect_pc = w_mispred ? w_actual : 32'd0;

    // ID/EX tracking; a flush wins over a stall so wrong-path work is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id      <= '0;
            r_ex      <= '0;
            r_ex_done <= 1'b0;
        end else if (w_mispred) begin
            r_id.v    <= 1'b0;
            r_ex.v    <= 1'b0;
            r_ex_done <= 1'b0;
        end else if (stall) begin
            r_ex_done <= r_ex_done | r_ex.v;
        end else begin
            r_id.v    <= if_valid;
            r_id.pc   <= if_pc;
            r_id.pred <= if_pred_npc;
            r_ex      <= r_id;
            r_ex_done <= 1'b0;
        end
    end

    // Statistics counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_eval && ex_is_branch) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_mispred) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
    assign drop_cnt    = r_drop_cnt;

    bpred_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_mispred),
        .i_push_data (w_push_data),
        .o_drop      (w_drop),
        .o_valid     (upd_valid),
        .o_data      (w_head),
        .i_ready     (upd_ready)
    );

    assign upd_idx    = w_head.idx;
    assign upd_target = w_head.target;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branch sequences push
// hand-computed BTB updates into a queue; a monitor pops and compares every
// accepted upd_* beat.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pred_npc;
    logic        stall;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        mispred;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        upd_valid;
    logic [6:0]  upd_idx;
    logic [31:0] upd_target;
    logic        upd_ready;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
    logic [31:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [38:0] sb_q [$];
    logic        ready_bg;
    int          exp_br  = 0;
    int          exp_mis = 0;
    int          exp_drp = 0;

    branch_resolve_unit dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_pred_npc  (if_pred_npc),
        .stall        (stall),
        .ex_is_branch (ex_is_branch),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target),
        .mispred      (mispred),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .upd_valid    (upd_valid),
        .upd_idx      (upd_idx),
        .upd_target   (upd_target),
        .upd_ready    (upd_ready),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_branch_cnt"}, branch_cnt, 32'(exp_br));
        chk({tag, "_mispred_cnt"}, mispred_cnt, 32'(exp_mis));
        chk({tag, "_drop_cnt"}, drop_cnt, 32'(exp_drp));
    endtask

    // Feed one instruction, a wrong-path follower, then resolve it in EX
    task automatic do_branch(input logic [31:0] pc, input logic [31:0] pred,
                             input logic isb, input logic tk, input logic [31:0] tgt,
                             input int nstall, input logic rdy_res,
                             input logic emis, input logic [31:0] erd,
                             input logic [6:0] eidx, input logic edrop);
        if_valid = 1'b1; if_pc = pc; if_pred_npc = pred;
        ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
        stall = 1'b0; upd_ready = ready_bg;
        tick();
        if_valid = 1'b1; if_pc = pc + 32'd4; if_pred_npc = pc + 32'd8;
        tick();
        if_valid = 1'b0;
        ex_is_branch = isb; ex_taken = tk; ex_target = tgt;
        stall = (nstall > 0); upd_ready = rdy_res;
        #1;
        chk("mispred", {31'd0, mispred}, {31'd0, emis});
        chk("flush", {31'd0, flush}, {31'd0, emis});
        chk("redirect_pc", redirect_pc, emis ? erd : 32'd0);
        if (emis && !edrop) sb_q.push_back({eidx, erd});
        if (isb) exp_br++;
        if (emis) exp_mis++;
        if (edrop) exp_drp++;
        tick();
        upd_ready = ready_bg;
        for (int j = 1; j < nstall; j++) begin
            #1;
            chk("stall_no_reeval", {31'd0, mispred}, 32'd0);
            tick();
        end
        stall = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
    endtask

    // Monitor: every accepted head beat must match the oldest expectation
    initial begin
        logic [38:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (upd_valid === 1'b1 && upd_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL upd_unexpected: got idx 0x%02h target 0x%08h expected none",
                             upd_idx, upd_target);
                end else begin
                    e = sb_q.pop_front();
                    if ({upd_idx, upd_target} !== e) begin
                        errors++;
                        $display("FAIL upd_entry: got idx 0x%02h target 0x%08h expected idx 0x%02h target 0x%08h",
                                 upd_idx, upd_target, e[38:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = 32'd0; if_pred_npc = 32'd0;
        stall = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
        upd_ready = 1'b0; ready_bg = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_mispred", {31'd0, mispred}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst_upd_idx", {25'd0, upd_idx}, 32'd0);
        chk("rst_upd_target", upd_target, 32'd0);
        chk_cnts("rst");

        // 1: straight-line code, all predictions pc+4
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if_valid = (i < 8); if_pc = 32'(i * 4); if_pred_npc = 32'(i * 4 + 4);
            #1;
            chk("s1_mispred", {31'd0, mispred}, 32'd0);
            tick();
        end
        if_valid = 1'b0;
        chk("s1_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk_cnts("s1");

        // 2: taken branch at 0x40 predicted fall-through
        ready_bg = 1'b1;
        do_branch(32'h40, 32'h44, 1'b1, 1'b1, 32'h100, 0, 1'b1, 1'b1, 32'h100, 7'h10, 1'b0);
        // Wrong-path 0x44 would now be in EX had the flush not cleared it
        ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h999;
        #1;
        chk("s2_ex_flushed", {31'd0, mispred}, 32'd0);
        chk("s2_upd_valid", {31'd0, upd_valid}, 32'd1);
        tick();
        ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
        tick();
        chk_cnts("s2");

        // 3a: mispredicting branch held in EX by a 3-cycle stall
        do_branch(32'h40, 32'h44, 1'b1, 1'b1, 32'h100, 3, 1'b1, 1'b1, 32'h100, 7'h10, 1'b0);
        // 3b: correctly predicted taken branch stalled 3 cycles counts once
        do_branch(32'h80, 32'h200, 1'b1, 1'b1, 32'h200, 3, 1'b1, 1'b0, 32'h200, 7'h20, 1'b0);
        tick();
        tick();
        chk_cnts("s3");

        // 4: five mispredicts with the BTB not ready; the fifth is dropped
        ready_bg = 1'b0;
        do_branch(32'h100, 32'h104, 1'b1, 1'b1, 32'h1000, 0, 1'b0, 1'b1, 32'h1000, 7'h40, 1'b0);
        do_branch(32'h110, 32'h114, 1'b1, 1'b1, 32'h1100, 0, 1'b0, 1'b1, 32'h1100, 7'h44, 1'b0);
        do_branch(32'h120, 32'h500, 1'b0, 1'b0, 32'h0,    0, 1'b0, 1'b1, 32'h124,  7'h48, 1'b0);
        do_branch(32'h130, 32'h134, 1'b1, 1'b1, 32'h1300, 0, 1'b0, 1'b1, 32'h1300, 7'h4C, 1'b0);
        do_branch(32'h140, 32'h144, 1'b1, 1'b1, 32'h1400, 0, 1'b0, 1'b1, 32'h1400, 7'h50, 1'b1);
        #1;
        chk("s4_full_valid", {31'd0, upd_valid}, 32'd1);
        chk("s4_head_idx", {25'd0, upd_idx}, 32'h40);
        chk("s4_head_target", upd_target, 32'h1000);
        chk_cnts("s4");
        ready_bg = 1'b1; upd_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("s4_drained", {31'd0, upd_valid}, 32'd0);

        // 5: full FIFO, pop and push in the same cycle -> no drop
        ready_bg = 1'b0;
        do_branch(32'h180, 32'h184, 1'b1, 1'b1, 32'h2000, 0, 1'b0, 1'b1, 32'h2000, 7'h60, 1'b0);
        do_branch(32'h190, 32'h194, 1'b1, 1'b1, 32'h2100, 0, 1'b0, 1'b1, 32'h2100, 7'h64, 1'b0);
        do_branch(32'h1A0, 32'h1A4, 1'b1, 1'b1, 32'h2200, 0, 1'b0, 1'b1, 32'h2200, 7'h68, 1'b0);
        do_branch(32'h1B0, 32'h1B4, 1'b1, 1'b1, 32'h2300, 0, 1'b0, 1'b1, 32'h2300, 7'h6C, 1'b0);
        do_branch(32'h1C0, 32'h1C4, 1'b1, 1'b1, 32'h2400, 0, 1'b1, 1'b1, 32'h2400, 7'h70, 1'b0);
        ready_bg = 1'b1; upd_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("s5_drained", {31'd0, upd_valid}, 32'd0);
        chk_cnts("s5");

        // 6: reset with two queued entries and a mispredicting branch in EX
        ready_bg = 1'b0;
        do_branch(32'h1D0, 32'h1D4, 1'b1, 1'b1, 32'h3000, 0, 1'b0, 1'b1, 32'h3000, 7'h74, 1'b0);
        do_branch(32'h1E0, 32'h1E4, 1'b1, 1'b1, 32'h3100, 0, 1'b0, 1'b1, 32'h3100, 7'h78, 1'b0);
        upd_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h1F0; if_pred_npc = 32'h1F4;
        tick();
        if_valid = 1'b0;
        tick();
        ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h700;
        rst = 1'b1;
        sb_q.delete();
        exp_br = 0; exp_mis = 0; exp_drp = 0;
        tick();
        rst = 1'b0;
        #1;
        chk("s6_mispred", {31'd0, mispred}, 32'd0);
        chk("s6_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk_cnts("s6");
        ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
        upd_ready = 1'b1;
        tick();
        tick();
        chk("s6_upd_valid_later", {31'd0, upd_valid}, 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
